// File: rtl/sprite_scheduler.sv
// Four-sprite scheduler sharing one synchronous sprite ROM in the VGA chain.
// Shadow config is committed on vsync rise; pixels pass through a 3-stage pipeline.
module sprite_scheduler #(
    parameter int          N_SPR        = 4,
    parameter int          SPR_W        = 48,
    parameter int          SPR_H        = 64,
    parameter logic [11:0] KEY          = 12'hF0F,
    parameter int          VGA_BUS_SIZE = 40
) (
    input  logic                    pclk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [1:0]              cfg_idx,
    input  logic [11:0]             cfg_x,
    input  logic [11:0]             cfg_y,
    input  logic                    cfg_en,
    input  logic [VGA_BUS_SIZE-1:0] vga_in,
    output logic [VGA_BUS_SIZE-1:0] vga_out,
    output logic [13:0]             rom_addr,
    input  logic [11:0]             rom_data,
    output logic                    frame_tick,
    output logic [N_SPR-1:0]        ovl_mask
);
    localparam int IDX_W = $clog2(N_SPR);

    // Bus layout: {hcount[11:0], vcount[11:0], hsync, vsync, hblnk, vblnk, rgb[11:0]}
    logic [11:0] w_h, w_v;
    logic        w_vsync, w_hblnk, w_vblnk;
    assign w_h     = vga_in[39:28];
    assign w_v     = vga_in[27:16];
    assign w_vsync = vga_in[14];
    assign w_hblnk = vga_in[13];
    assign w_vblnk = vga_in[12];

    logic [11:0]       r_sh_x  [N_SPR];
    logic [11:0]       r_sh_y  [N_SPR];
    logic [N_SPR-1:0]  r_sh_en;
    logic [11:0]       r_act_x [N_SPR];
    logic [11:0]       r_act_y [N_SPR];
    logic [N_SPR-1:0]  r_act_en;
    logic              r_vsync_prev, r_armed;
    logic [N_SPR-1:0]  r_acc;
    logic              r_hit1, r_hit2;
    logic [VGA_BUS_SIZE-1:0] r_vga1, r_vga2;

    logic              w_commit, w_cfg_we, w_hit, w_multi;
    logic [N_SPR-1:0]  w_cover;
    logic [IDX_W-1:0]  w_win;
    logic [5:0]        w_row, w_col;
    logic [11:0]       w_rgb_mix;

    // r_armed masks a vsync that is already high when reset releases.
    assign w_commit   = r_armed & w_vsync & ~r_vsync_prev;
    assign frame_tick = w_commit;
    assign cfg_ready  = rst_n & ~w_commit;
    assign w_cfg_we   = cfg_valid & cfg_ready;

    // Vsync edge detector and post-reset arming flag.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_prev <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_vsync_prev <= w_vsync;
            r_armed      <= 1'b1;
        end
    end

    // Shadow config writes and atomic commit into the active set.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SPR; i++) begin
                r_sh_x[i]  <= 12'd0;
                r_sh_y[i]  <= 12'd0;
                r_act_x[i] <= 12'd0;
                r_act_y[i] <= 12'd0;
            end
            r_sh_en  <= '0;
            r_act_en <= '0;
        end else begin
            if (w_cfg_we) begin
                r_sh_x[cfg_idx]  <= cfg_x;
                r_sh_y[cfg_idx]  <= cfg_y;
                r_sh_en[cfg_idx] <= cfg_en;
            end
            if (w_commit) begin
                r_act_x  <= r_sh_x;
                r_act_y  <= r_sh_y;
                r_act_en <= r_sh_en;
            end
        end
    end

    // Per-sprite cover test with 13-bit bounds so right/bottom edges never wrap.
    always_comb begin
        w_cover = '0;
        for (int i = 0; i < N_SPR; i++) begin
            w_cover[i] = r_act_en[i] & ~w_hblnk & ~w_vblnk
                       & ({1'b0, w_h} >= {1'b0, r_act_x[i]})
                       & ({1'b0, w_h} <  ({1'b0, r_act_x[i]} + 13'(SPR_W)))
                       & ({1'b0, w_v} >= {1'b0, r_act_y[i]})
                       & ({1'b0, w_v} <  ({1'b0, r_act_y[i]} + 13'(SPR_H)));
        end
    end

    // Fixed-priority winner: scanning downward leaves the lowest covering index.
    always_comb begin
        w_win = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (w_cover[i]) begin
                w_win = IDX_W'(i);
            end else begin
                w_win = w_win;
            end
        end
    end

    assign w_hit   = |w_cover;
    assign w_multi = |(w_cover & (w_cover - N_SPR'(1)));
    assign w_row   = 6'(w_v - r_act_y[w_win]);
    assign w_col   = 6'(w_h - r_act_x[w_win]);

    // Stage 1/2: ROM address, hit flag and VGA delay line.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= 14'd0;
            r_hit1   <= 1'b0;
            r_hit2   <= 1'b0;
            r_vga1   <= '0;
            r_vga2   <= '0;
        end else begin
            if (w_hit) begin
                rom_addr <= {w_win, w_row, w_col};
            end else begin
                rom_addr <= rom_addr;
            end
            r_hit1 <= w_hit;
            r_hit2 <= r_hit1;
            r_vga1 <= vga_in;
            r_vga2 <= r_vga1;
        end
    end

    // Pixel mix: ROM pixel wins unless it is the transparent key.
    always_comb begin
        if (r_hit2 && (rom_data != KEY)) begin
            w_rgb_mix = rom_data;
        end else begin
            w_rgb_mix = r_vga2[11:0];
        end
    end

    // Stage 3: registered VGA output.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out <= '0;
        end else begin
            vga_out <= {r_vga2[VGA_BUS_SIZE-1:12], w_rgb_mix};
        end
    end

    // Overlap accumulator; a set in the commit cycle belongs to the new frame.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            ovl_mask <= '0;
        end else if (w_commit) begin
            ovl_mask <= r_acc;
            r_acc    <= w_multi ? w_cover : '0;
        end else if (w_multi) begin
            r_acc    <= r_acc | w_cover;
        end else begin
            r_acc    <= r_acc;
        end
    end
endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: expected vga_out words are queued
// when a pixel is driven and popped three cycles later.
module tb_sprite_scheduler;
    logic        pclk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_idx;
    logic [11:0] cfg_x, cfg_y;
    logic        cfg_en;
    logic [39:0] vga_in;
    logic [39:0] vga_out;
    logic [13:0] rom_addr;
    logic [11:0] rom_data;
    logic        frame_tick;
    logic [3:0]  ovl_mask;

    logic [11:0] rom_fill;
    logic [39:0] exp_q[$];
    logic [39:0] exp_w;
    int checks = 0;
    int errors = 0;

    sprite_scheduler dut (
        .pclk(pclk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
        .vga_in(vga_in), .vga_out(vga_out),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .frame_tick(frame_tick), .ovl_mask(ovl_mask)
    );

    always #5 pclk = ~pclk;

    // Synchronous ROM model: one cycle from address to data.
    always @(posedge pclk) rom_data <= (rom_addr == 14'h3FFF) ? 12'h000 : rom_fill;

    task automatic send(input logic [11:0] h, input logic [11:0] v, input logic hb,
                        input logic [11:0] rgb, input logic draw);
        @(negedge pclk);
        vga_in = {h, v, h[0], 1'b0, hb, 1'b0, rgb};
        exp_q.push_back({h, v, h[0], 1'b0, hb, 1'b0, draw ? rom_fill : rgb});
    endtask

    task automatic idle();
        @(negedge pclk);
        vga_in = {12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
    endtask

    task automatic write_cfg(input logic [1:0] idx, input logic [11:0] x,
                             input logic [11:0] y, input logic en);
        @(negedge pclk);
        cfg_valid = 1'b1; cfg_idx = idx; cfg_x = x; cfg_y = y; cfg_en = en;
        @(negedge pclk);
        cfg_valid = 1'b0;
    endtask

    task automatic commit();
        idle();
        @(negedge pclk);
        vga_in[14] = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        vga_in[14] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_idx = 2'd0; cfg_x = 12'd0; cfg_y = 12'd0;
        cfg_en = 1'b0; rom_fill = 12'h0F0;
        vga_in = {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000};
        repeat (3) @(negedge pclk);
        checks++; if (vga_out !== 40'd0) begin errors++; $display("FAIL reset_vga_out got=%h exp=0", vga_out); end
        checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=0", cfg_ready); end
        checks++; if ({frame_tick, ovl_mask} !== 5'd0) begin errors++; $display("FAIL reset_tick_ovl got=%b exp=0", {frame_tick, ovl_mask}); end
        rst_n = 1'b1;
        #1;
        checks++; if ({cfg_ready, frame_tick} !== 2'b10) begin errors++; $display("FAIL release_vsync_high got=%b exp=10", {cfg_ready, frame_tick}); end
        @(negedge pclk);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL release_no_commit got=%b exp=0", frame_tick); end
        write_cfg(2'd0, 12'd100, 12'd200, 1'b1);
        send(12'd100, 12'd200, 1'b0, 12'h123, 1'b0);
        @(negedge pclk);
        checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL nocommit_addr got=%h exp=0", rom_addr); end
        repeat (2) @(negedge pclk);
        exp_w = exp_q.pop_front();
        checks++; if (vga_out !== exp_w) begin errors++; $display("FAIL nocommit_vga got=%h exp=%h", vga_out, exp_w); end
    endtask

    task automatic test_single();
        int          hs[4] = '{147, 148, 100, 99};
        int          vs[4] = '{263, 200, 200, 200};
        logic        dr[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [13:0] ea[4] = '{14'h0FEF, 14'h0FEF, 14'h0000, 14'h0000};
        commit();
        for (int k = 0; k < 4; k++) begin
            send(12'(hs[k]), 12'(vs[k]), 1'b0, 12'(12'h200 + k), dr[k]);
            @(negedge pclk);
            checks++; if (rom_addr !== ea[k]) begin errors++; $display("FAIL single_addr[%0d] got=%h exp=%h", k, rom_addr, ea[k]); end
            repeat (2) @(negedge pclk);
            exp_w = exp_q.pop_front();
            checks++; if (vga_out !== exp_w) begin errors++; $display("FAIL single_vga[%0d] got=%h exp=%h", k, vga_out, exp_w); end
        end
        idle();
    endtask

    task automatic test_transparency();
        rom_fill = 12'hF0F;
        send(12'd120, 12'd230, 1'b0, 12'h456, 1'b0);
        @(negedge pclk);
        checks++; if (rom_addr !== 14'h0794) begin errors++; $display("FAIL transp_addr got=%h exp=0794", rom_addr); end
        repeat (2) @(negedge pclk);
        exp_w = exp_q.pop_front();
        checks++; if (vga_out !== exp_w) begin errors++; $display("FAIL transp_vga got=%h exp=%h", vga_out, exp_w); end
        rom_fill = 12'h0F0;
        idle();
    endtask

    task automatic test_priority_overlap();
        int          hs[3] = '{300, 310, 300};
        int          vs[3] = '{300, 305, 300};
        logic        hb[3] = '{1'b0, 1'b0, 1'b1};
        logic        dr[3] = '{1'b1, 1'b1, 1'b0};
        logic [13:0] ea[3] = '{14'h1000, 14'h114A, 14'h114A};
        write_cfg(2'd1, 12'd300, 12'd300, 1'b1);
        write_cfg(2'd2, 12'd300, 12'd300, 1'b1);
        commit();
        checks++; if (ovl_mask !== 4'b0000) begin errors++; $display("FAIL ovl_before got=%b exp=0000", ovl_mask); end
        for (int k = 0; k < 3; k++) begin
            send(12'(hs[k]), 12'(vs[k]), hb[k], 12'(12'h300 + k), dr[k]);
            @(negedge pclk);
            checks++; if (rom_addr !== ea[k]) begin errors++; $display("FAIL prio_addr[%0d] got=%h exp=%h", k, rom_addr, ea[k]); end
            repeat (2) @(negedge pclk);
            exp_w = exp_q.pop_front();
            checks++; if (vga_out !== exp_w) begin errors++; $display("FAIL prio_vga[%0d] got=%h exp=%h", k, vga_out, exp_w); end
            if (k == 1) begin
                commit();
                checks++; if (ovl_mask !== 4'b0110) begin errors++; $display("FAIL ovl_set got=%b exp=0110", ovl_mask); end
            end
        end
        commit();
        checks++; if (ovl_mask !== 4'b0000) begin errors++; $display("FAIL ovl_clear got=%b exp=0000", ovl_mask); end
    endtask

    task automatic test_commit_handshake();
        idle();
        @(negedge pclk);
        vga_in[14] = 1'b1;
        cfg_valid = 1'b1; cfg_idx = 2'd3; cfg_x = 12'd500; cfg_y = 12'd100; cfg_en = 1'b1;
        #1;
        checks++; if ({cfg_ready, frame_tick} !== 2'b01) begin errors++; $display("FAIL hs_commit_cycle got=%b exp=01", {cfg_ready, frame_tick}); end
        @(negedge pclk);
        #1;
        checks++; if ({cfg_ready, frame_tick} !== 2'b10) begin errors++; $display("FAIL hs_after_commit got=%b exp=10", {cfg_ready, frame_tick}); end
        @(negedge pclk);
        cfg_valid = 1'b0;
        send(12'd500, 12'd100, 1'b0, 12'h777, 1'b0);
        @(negedge pclk);
        checks++; if (rom_addr !== 14'h114A) begin errors++; $display("FAIL hs_hidden_addr got=%h exp=114a", rom_addr); end
        repeat (2) @(negedge pclk);
        exp_w = exp_q.pop_front();
        checks++; if (vga_out !== exp_w) begin errors++; $display("FAIL hs_hidden_vga got=%h exp=%h", vga_out, exp_w); end
        commit();
        send(12'd500, 12'd100, 1'b0, 12'h778, 1'b1);
        @(negedge pclk);
        checks++; if (rom_addr !== 14'h3000) begin errors++; $display("FAIL hs_visible_addr got=%h exp=3000", rom_addr); end
        repeat (2) @(negedge pclk);
        exp_w = exp_q.pop_front();
        checks++; if (vga_out !== exp_w) begin errors++; $display("FAIL hs_visible_vga got=%h exp=%h", vga_out, exp_w); end
        idle();
    endtask

    task automatic test_edge();
        int          hs[2] = '{4095, 2};
        logic        dr[2] = '{1'b1, 1'b0};
        logic [13:0] ea[2] = '{14'h0285, 14'h0285};
        write_cfg(2'd0, 12'd4090, 12'd0, 1'b1);
        commit();
        for (int k = 0; k < 2; k++) begin
            send(12'(hs[k]), 12'd10, 1'b0, 12'(12'h400 + k), dr[k]);
            @(negedge pclk);
            checks++; if (rom_addr !== ea[k]) begin errors++; $display("FAIL edge_addr[%0d] got=%h exp=%h", k, rom_addr, ea[k]); end
            repeat (2) @(negedge pclk);
            exp_w = exp_q.pop_front();
            checks++; if (vga_out !== exp_w) begin errors++; $display("FAIL edge_vga[%0d] got=%h exp=%h", k, vga_out, exp_w); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_transparency();
        test_priority_overlap();
        test_commit_handshake();
        test_edge();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Shares one synchronous sprite ROM among four on-screen sprites (player cars, gremlins) in the DeathRace VGA pipeline. The block holds per-sprite position/enable registers, reconfigured through a valid/ready port and committed atomically at frame start. Per pixel it picks the highest-priority sprite covering it, drives the ROM address and replaces `rgb` with the ROM pixel unless that pixel is the transparent key. It sits in the VGA chain after the background stage, in place of a single-sprite drawer, and also reports per-frame bounding-box overlap for the collision logic.

## Interface
- `N_SPR`, 4: sprite count. Index width is 2 bits.
- `SPR_W`, 48: sprite width in pixels.
- `SPR_H`, 64: sprite height in pixels.
- `KEY`, 12'hF_0_F: transparent colour.

- `pclk` in 1: pixel clock. All state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_valid` in 1: config write request.
- `cfg_ready` out 1: config write can be accepted.
- `cfg_idx` in 2: sprite being written.
- `cfg_x` in 12: sprite left edge.
- `cfg_y` in 12: sprite top edge.
- `cfg_en` in 1: sprite visible.
- `vga_in` in `VGA_BUS_SIZE`: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb.
- `vga_out` out `VGA_BUS_SIZE`: same fields, delayed 3 cycles, rgb possibly replaced.
- `rom_addr` out 14: ROM address, `{idx[1:0], row[5:0], col[5:0]}`.
- `rom_data` in 12: ROM pixel, valid 1 cycle after `rom_addr`.
- `frame_tick` out 1: 1-cycle pulse on commit.
- `ovl_mask` out 4: per sprite, overlapped another sprite in the previous frame.

## Operation
- **Shadow registers.** Each sprite has shadow `x`, `y`, `en`.
  - A write happens when `cfg_valid && cfg_ready` and updates shadow entry `cfg_idx`.
  - A later write to the same index in the same frame overwrites the earlier one.
- **Commit.** Commit occurs on the rising edge of `vsync_in`: `vsync_in == 1` while the registered previous value is 0.
  - Active registers load all shadow entries.
  - `frame_tick` pulses for that cycle.
  - `cfg_ready` is 0 only during the commit cycle, so a write never races a commit. Otherwise `cfg_ready` is 1.
- **Cover test.** Sprite i covers a pixel when all of these hold:
  - active `en[i]`;
  - `hcount >= x[i]` and `hcount < x[i]+SPR_W`;
  - `vcount >= y[i]` and `vcount < y[i]+SPR_H`;
  - `hblnk == 0` and `vblnk == 0`.
  - Sums are computed 13 bits wide, so a sprite near 4095 does not wrap to column 0.
- **Arbitration.** Fixed priority, lowest index wins.
  - `row = vcount - y[w]` and `col = hcount - x[w]`, truncated to 6 bits, where w is the winner.
  - When no sprite covers the pixel, `rom_addr` holds its previous value and the hit flag is 0.
- **Mixing.** Output `rgb = rom_data` if the delayed hit flag is 1 and `rom_data != KEY`; otherwise the delayed `rgb_in`.
- **Overlap.**
  - If two or more sprites cover the same pixel, every covering sprite's bit is set in an accumulator.
  - At commit, `ovl_mask` loads the accumulator and the accumulator clears. A coincident set in the commit cycle lands in the new accumulator.

## Timing
- Cycle t: `vga_in` is sampled.
- Cycle t+1: `rom_addr` and the hit flag are registered.
- Cycle t+2: `rom_data` is valid from the ROM.
- Cycle t+3: `vga_out` is registered. Every VGA field has exactly 3 cycles of latency, sync and blank included.
- Commit takes effect for pixels sampled from the cycle after the commit cycle onward.
- Reset values:
  - `vga_out`: all 0.
  - `rom_addr`: 0.
  - `frame_tick`: 0.
  - `ovl_mask`: 0.
  - `cfg_ready`: 1 after reset release; 0 during reset.
  - All shadow and active registers: 0, so every sprite is disabled.
  - Previous-vsync register: 0.
- If reset is asserted mid-frame, no sprite draws until it has been written and a commit has occurred.
- If `vsync_in` is high at reset release, that cycle is not a rising edge. The first commit happens on the next 0→1 transition.

## Test plan
- **Reset.** Reset, write sprite 0 at (100,200) with `en=1`, and never commit → `vga_out.rgb` equals `rgb_in` delayed by 3 cycles; `rom_addr` stays 0.
- **Single sprite.** Write sprite 0 at (100,200), `en=1`, then commit.
  - Pixel (100,200) → `rom_addr = 0x0000`.
  - Pixel (147,263) → `rom_addr = {0,63,47} = 0x0FEF`.
  - Pixel (148,200) → no hit.
  - With `rom_data = 12'h0F0`, output rgb at t+3 is `12'h0F0`.
- **Transparency.** Same setup with `rom_data = 12'hF0F` inside the sprite → output rgb equals the delayed `rgb_in`.
- **Priority and overlap.** Sprites 1 and 2 both at (300,300).
  - Pixel (300,300) → `rom_addr[13:12] = 1`.
  - After the next commit → `ovl_mask = 4'b0110`.
  - After one frame with no overlap → `ovl_mask = 0`.
- **Commit handshake.** Hold `cfg_valid = 1` across a vsync rising edge → `cfg_ready` is 0 for exactly that cycle and `frame_tick` is 1 in the same cycle. The held write is accepted the next cycle and becomes visible only after the following commit.
- **Edge cases.**
  - Sprite at x=4090, pixel hcount=2 → no hit, since there is no wrap.
  - `hblnk = 1` inside the sprite box → no hit and no overlap accumulation.
